// File: rtl/ysyx_23060332_dmem_resp.sv
// rtl/ysyx_23060332_dmem_resp.sv - data-memory responder with valid/ready handshake and programmable latency
// One request in flight; the access executes on the edge that enters RESP.
module ysyx_23060332_dmem_resp #(
   parameter int unsigned DEPTH     = 1024,
   parameter logic [31:0] BASE_ADDR = 32'h80000000,
   parameter int unsigned LATENCY   = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_wen_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   input  logic [7:0]  req_wmask_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_err_o
);

   localparam int unsigned AW    = $clog2(DEPTH);
   localparam logic [31:0] LIMIT = 32'(4 * DEPTH);
   localparam logic [3:0]  LAT   = 4'(LATENCY);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        wen_q, wen_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  wmask_q, wmask_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;
   logic        rsp_err_q, rsp_err_d;

   logic [31:0] mem_q [DEPTH];

   logic          src_wen;
   logic [31:0]   src_addr;
   logic [31:0]   src_wdata;
   logic [3:0]    src_wmask;
   logic [31:0]   off;
   logic [AW-1:0] idx;
   logic          acc_err;
   logic          exec;
   logic          mem_we;
   logic          unused_wmask;

   assign unused_wmask = ^req_wmask_i[7:4];

   // With zero latency the access executes on the accept edge, so it must use the live request.
   always_comb begin
      src_wen   = wen_q;
      src_addr  = addr_q;
      src_wdata = wdata_q;
      src_wmask = wmask_q;
      if (state_q == S_IDLE) begin
         src_wen   = req_wen_i;
         src_addr  = req_addr_i;
         src_wdata = req_wdata_i;
         src_wmask = req_wmask_i[3:0];
      end
      off     = src_addr - BASE_ADDR;
      idx     = off[AW+1:2];
      acc_err = (src_addr[1:0] != 2'b00) || (off >= LIMIT);
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      wen_d       = wen_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wmask_d     = wmask_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      exec        = 1'b0;
      mem_we      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (req_valid_i) begin
               wen_d   = req_wen_i;
               addr_d  = req_addr_i;
               wdata_d = req_wdata_i;
               wmask_d = req_wmask_i[3:0];
               cnt_d   = LAT;
               state_d = (LAT == 4'd0) ? S_RESP : S_WAIT;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            if (rsp_ready_i) begin
               state_d     = S_IDLE;
               rsp_rdata_d = '0;
               rsp_err_d   = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase

      exec = (state_q != S_RESP) && (state_d == S_RESP);
      if (exec) begin
         rsp_err_d   = acc_err;
         rsp_rdata_d = (!src_wen && !acc_err) ? mem_q[idx] : '0;
         mem_we      = src_wen && !acc_err;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         wen_q       <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wmask_q     <= '0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         wen_q       <= wen_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wmask_q     <= wmask_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   // Array is deliberately not reset; writes are blocked while reset is held.
   always_ff @(posedge clk_i) begin
      if (mem_we && !rst_i) begin
         for (int i = 0; i < 4; i++) begin
            if (src_wmask[i]) begin
               mem_q[idx][8*i +: 8] <= src_wdata[8*i +: 8];
            end
         end
      end
   end

   assign req_ready_o = (state_q == S_IDLE);
   assign rsp_valid_o = (state_q == S_RESP);
   assign rsp_rdata_o = rsp_rdata_q;
   assign rsp_err_o   = rsp_err_q;

endmodule
